// File: rtl/acc_ctrl_if.sv
// Control/datapath bundle for the accumulator processor sequencer.
// The master side is the sequencer; the slave side is the datapath and memory port.
interface acc_ctrl_if;
   logic [7:0] ir;
   logic       acc_zero;
   logic       mem_ack;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_ld;
   logic       pc_inc;
   logic       pc_ld;
   logic [1:0] alu_op;
   logic [1:0] acc_src;
   logic       en_da;

   modport master (
      input  ir, acc_zero, mem_ack,
      output mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, alu_op, acc_src, en_da
   );

   modport slave (
      output ir, acc_zero, mem_ack,
      input  mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, alu_op, acc_src, en_da
   );
endinterface

// File: rtl/acc_ctrl.sv
// Fetch/decode/memory sequencer for the 8-bit accumulator processor.
// Holds only the state, a memory-wait timeout counter and the sticky error flag.
module acc_ctrl #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   acc_ctrl_if.master  bus,
   output logic        halted,
   output logic        err,
   output logic [2:0]  state
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 8;

   localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] S_FETCH  = 3'd1;
   localparam logic [STATE_W-1:0] S_DECODE = 3'd2;
   localparam logic [STATE_W-1:0] S_MEMRD  = 3'd3;
   localparam logic [STATE_W-1:0] S_MEMWR  = 3'd4;
   localparam logic [STATE_W-1:0] S_HALT   = 3'd5;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_LDI = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [STATE_W-1:0] state_nx;
   logic [STATE_W-1:0] resume;
   logic [CNT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]   wait_cnt_nx;
   logic               err_nx;
   logic [3:0]         opcode;
   logic               in_mem;
   logic               expired;
   logic               unused_operand;

   assign opcode  = bus.ir[7:4];
   assign in_mem  = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   // Ack in the same cycle the count reaches the limit still wins.
   assign expired = in_mem && !bus.mem_ack && (wait_cnt >= CNT_W'(WAIT_MAX));
   // Every path back to FETCH is diverted to IDLE while run is low.
   assign resume  = run ? S_FETCH : S_IDLE;
   // Operand bits feed the datapath address/immediate muxes, not the sequencer.
   assign unused_operand = ^bus.ir[3:0];

   // State, wait counter and sticky error register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         err      <= err_nx;
      end
   end

   // Next-state, timeout and error logic.
   always_comb begin
      state_nx = state;
      err_nx   = err;
      case (state)
         S_IDLE:   if (run) state_nx = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ack) state_nx = S_DECODE;
            else if (expired) begin
               state_nx = S_HALT;
               err_nx   = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB: state_nx = S_MEMRD;
               OP_STA:                 state_nx = S_MEMWR;
               OP_HLT:                 state_nx = S_HALT;
               default:                state_nx = resume;
            endcase
         end
         S_MEMRD, S_MEMWR: begin
            if (bus.mem_ack) state_nx = resume;
            else if (expired) begin
               state_nx = S_HALT;
               err_nx   = 1'b1;
            end
         end
         S_HALT:   state_nx = S_HALT;
         default: begin
            state_nx = S_HALT;
            err_nx   = 1'b1;
         end
      endcase
      wait_cnt_nx = (in_mem && (state_nx == state)) ? wait_cnt + CNT_W'(1) : '0;
   end

   // Strobes decoded from the current state, opcode, acc_zero and mem_ack.
   always_comb begin
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.addr_sel = 1'b0;
      bus.ir_ld    = 1'b0;
      bus.pc_inc   = 1'b0;
      bus.pc_ld    = 1'b0;
      bus.alu_op   = 2'b00;
      bus.acc_src  = 2'b00;
      bus.en_da    = 1'b0;
      halted       = 1'b0;
      case (state)
         S_FETCH: begin
            bus.mem_req = 1'b1;
            bus.ir_ld   = bus.mem_ack;
            bus.pc_inc  = bus.mem_ack;
         end
         S_DECODE: begin
            case (opcode)
               OP_JMP: bus.pc_ld = 1'b1;
               OP_JZ:  bus.pc_ld = bus.acc_zero;
               OP_LDI: begin
                  bus.en_da   = 1'b1;
                  bus.acc_src = 2'b10;
               end
               default: ;
            endcase
         end
         S_MEMRD: begin
            bus.mem_req  = 1'b1;
            bus.addr_sel = 1'b1;
            case (opcode)
               OP_ADD:  bus.alu_op = 2'b01;
               OP_SUB:  bus.alu_op = 2'b10;
               default: bus.alu_op = 2'b00;
            endcase
            if (bus.mem_ack) begin
               bus.en_da   = 1'b1;
               bus.acc_src = (opcode == OP_LDA) ? 2'b01 : 2'b00;
            end
         end
         S_MEMWR: begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = 1'b1;
            bus.addr_sel = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_acc_ctrl.sv
// Bench for acc_ctrl: small datapath/memory around the sequencer, a cycle
// model of the control rules, an ISA interpreter and directed programs.
module tb_acc_ctrl;
   localparam int unsigned WAIT_MAX = 15;

   localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMRD = 3, PH_MEMWR = 4, PH_HALT = 5;
   localparam int K_NOP = 0, K_RD = 1, K_WR = 2, K_JMP = 3, K_JZ = 4, K_LDI = 5, K_HLT = 6;

   logic clk = 1'b0;
   logic clr, run, ack;
   logic halted, err;
   logic [2:0] state;

   acc_ctrl_if bus();

   acc_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk    (clk),
      .clr    (clr),
      .run    (run),
      .bus    (bus.master),
      .halted (halted),
      .err    (err),
      .state  (state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   // ---------------- datapath and memory ----------------
   logic [7:0] prog [16];
   logic [7:0] mem  [16];
   logic [3:0] pc_q;
   logic [7:0] ir_q, acc_q;
   logic [3:0] dp_addr;
   logic [7:0] dp_rd;

   assign bus.ir       = ir_q;
   assign bus.acc_zero = (acc_q == 8'd0);
   assign bus.mem_ack  = ack;
   assign dp_addr      = bus.addr_sel ? ir_q[3:0] : pc_q;
   assign dp_rd        = mem[dp_addr];

   always @(posedge clk or negedge clr) begin
      if (!clr) begin
         pc_q  <= 4'd0;
         ir_q  <= 8'd0;
         acc_q <= 8'd0;
         for (int i = 0; i < 16; i++) mem[i] <= prog[i];
      end else begin
         if (bus.ir_ld) ir_q <= dp_rd;
         if (bus.pc_ld) pc_q <= ir_q[3:0];
         else if (bus.pc_inc) pc_q <= pc_q + 4'd1;
         if (bus.en_da) begin
            case (bus.acc_src)
               2'd1:    acc_q <= dp_rd;
               2'd2:    acc_q <= {4'h0, ir_q[3:0]};
               default: case (bus.alu_op)
                           2'd1:    acc_q <= acc_q + dp_rd;
                           2'd2:    acc_q <= acc_q - dp_rd;
                           default: acc_q <= dp_rd;
                        endcase
            endcase
         end
         if (bus.mem_req && bus.mem_we && bus.mem_ack) mem[dp_addr] <= acc_q;
      end
   end

   // ---------------- cycle model of the control rules ----------------
   int          m_phase;
   int unsigned m_wait;
   logic        m_err;

   function automatic int kind_of(input logic [3:0] op);
      case (op)
         4'h1, 4'h3, 4'h4: return K_RD;
         4'h2: return K_WR;
         4'h5: return K_JMP;
         4'h6: return K_JZ;
         4'h7: return K_LDI;
         4'hF: return K_HLT;
         default: return K_NOP;
      endcase
   endfunction

   // {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld, alu_op, acc_src, en_da, halted, err, state}
   function automatic logic [15:0] exp_vec(input int ph, input logic [7:0] ir, input logic az,
                                           input logic ak, input logic er);
      logic req, we, asel, irld, pinc, pld, enda, hal;
      logic [1:0] aop, asrc;
      int k;
      req = 0; we = 0; asel = 0; irld = 0; pinc = 0; pld = 0; enda = 0; hal = 0;
      aop = 2'd0; asrc = 2'd0;
      k = kind_of(ir[7:4]);
      if (ph == PH_FETCH) begin
         req = 1; irld = ak; pinc = ak;
      end else if (ph == PH_DECODE) begin
         if (k == K_JMP) pld = 1;
         if (k == K_JZ)  pld = az;
         if (k == K_LDI) begin enda = 1; asrc = 2'd2; end
      end else if (ph == PH_MEMRD) begin
         req = 1; asel = 1;
         aop = (ir[7:4] == 4'h3) ? 2'd1 : (ir[7:4] == 4'h4) ? 2'd2 : 2'd0;
         if (ak) begin enda = 1; asrc = (ir[7:4] == 4'h1) ? 2'd1 : 2'd0; end
      end else if (ph == PH_MEMWR) begin
         req = 1; we = 1; asel = 1;
      end else if (ph == PH_HALT) begin
         hal = 1;
      end
      return {req, we, asel, irld, pinc, pld, aop, asrc, enda, hal, er, 3'(ph)};
   endfunction

   always @(posedge clk or negedge clr) begin
      int nxt;
      bit waiting;
      if (!clr) begin
         m_phase <= PH_IDLE;
         m_wait  <= 0;
         m_err   <= 1'b0;
      end else begin
         nxt = m_phase;
         waiting = (m_phase == PH_FETCH) || (m_phase == PH_MEMRD) || (m_phase == PH_MEMWR);
         if (m_phase == PH_IDLE) begin
            if (run) nxt = PH_FETCH;
         end else if (m_phase == PH_DECODE) begin
            case (kind_of(bus.ir[7:4]))
               K_RD:    nxt = PH_MEMRD;
               K_WR:    nxt = PH_MEMWR;
               K_HLT:   nxt = PH_HALT;
               default: nxt = PH_FETCH;
            endcase
         end else if (waiting) begin
            if (ack) nxt = (m_phase == PH_FETCH) ? PH_DECODE : PH_FETCH;
            else if (m_wait == WAIT_MAX) begin
               nxt = PH_HALT;
               m_err <= 1'b1;
            end
         end
         if (nxt == PH_FETCH && !run) nxt = PH_IDLE;
         if (nxt != m_phase) m_wait <= 0;
         else if (waiting) m_wait <= m_wait + 1;
         m_phase <= nxt;
      end
   end

   logic [15:0] dut_vec;
   assign dut_vec = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_ld, bus.pc_inc, bus.pc_ld,
                     bus.alu_op, bus.acc_src, bus.en_da, halted, err, state};

   always @(negedge clk) begin
      if (chk_en) check("cycle", dut_vec, exp_vec(m_phase, bus.ir, bus.acc_zero, ack, m_err));
   end

   // ---------------- ISA interpreter ----------------
   logic [7:0] isa_mem [16];
   logic [7:0] isa_acc;

   task automatic isa_run();
      logic [3:0] pc;
      logic [7:0] ins;
      pc = 4'd0;
      isa_acc = 8'd0;
      for (int i = 0; i < 16; i++) isa_mem[i] = prog[i];
      for (int s = 0; s < 64; s++) begin
         ins = isa_mem[pc];
         pc  = pc + 4'd1;
         if (ins[7:4] == 4'hF) break;
         case (ins[7:4])
            4'h1: isa_acc = isa_mem[ins[3:0]];
            4'h2: isa_mem[ins[3:0]] = isa_acc;
            4'h3: isa_acc = isa_acc + isa_mem[ins[3:0]];
            4'h4: isa_acc = isa_acc - isa_mem[ins[3:0]];
            4'h5: pc = ins[3:0];
            4'h6: if (isa_acc == 8'd0) pc = ins[3:0];
            4'h7: isa_acc = {4'h0, ins[3:0]};
            default: ;
         endcase
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clear_prog();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   task automatic do_reset();
      clr = 1'b0; run = 1'b0; ack = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 clr = 1'b1;
   endtask

   task automatic wait_state(input logic [2:0] s, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      while (state != s && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(nm, 16'(state), 16'(s));
   endtask

   task automatic quiet_check(input string nm);
      int noisy;
      noisy = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 ack = ((i % 2) == 1);
         @(negedge clk);
         if (bus.mem_req || bus.mem_we || bus.ir_ld || bus.pc_inc || bus.pc_ld || bus.en_da ||
             !halted || state != 3'd5) noisy++;
      end
      check(nm, 16'(noisy), 16'd0);
   endtask

   task automatic clr_pulse(input string nm);
      @(posedge clk);
      #3 clr = 1'b0;
      #1;
      check({nm, "_state"}, 16'(state), 16'd0);
      check({nm, "_err"}, 16'(err), 16'd0);
      check({nm, "_halted"}, 16'(halted), 16'd0);
      @(posedge clk);
      #1 clr = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      clr = 1'b0; run = 1'b0; ack = 1'b0;
      clear_prog();
      do_reset();
      chk_en = 1'b1;
      check("reset_state", 16'(state), 16'd0);
      check("reset_err", 16'(err), 16'd0);

      // LDI 3 with ack tied high
      clear_prog(); prog[0] = 8'h73;
      do_reset(); run = 1'b1; ack = 1'b1;
      @(negedge clk); check("ldi_idle", 16'(state), 16'd0);
      @(negedge clk); check("ldi_fetch", 16'(state), 16'd1);
      check("ldi_fetch_pcinc", 16'(bus.pc_inc), 16'd1);
      check("ldi_fetch_irld", 16'(bus.ir_ld), 16'd1);
      @(negedge clk); check("ldi_decode", 16'(state), 16'd2);
      check("ldi_decode_enda", 16'(bus.en_da), 16'd1);
      check("ldi_decode_src", 16'(bus.acc_src), 16'd2);
      check("ldi_decode_pcinc", 16'(bus.pc_inc), 16'd0);
      @(negedge clk); check("ldi_refetch", 16'(state), 16'd1);
      check("ldi_acc", 16'(acc_q), 16'h03);
      @(posedge clk); #1 run = 1'b0;
      repeat (3) @(negedge clk);
      check("run_low_idle", 16'(state), 16'd0);

      // JMP 4; LDI 5; ADD @2; STA @3; HLT
      clear_prog();
      prog[0] = 8'h54; prog[2] = 8'h0A; prog[4] = 8'h75;
      prog[5] = 8'h32; prog[6] = 8'h23; prog[7] = 8'hF0;
      do_reset(); run = 1'b1; ack = 1'b1;
      wait_state(3'd3, "add_reach_memrd");
      check("add_aluop", 16'(bus.alu_op), 16'd1);
      check("add_src", 16'(bus.acc_src), 16'd0);
      check("add_enda", 16'(bus.en_da), 16'd1);
      check("add_addrsel", 16'(bus.addr_sel), 16'd1);
      wait_state(3'd4, "sta_reach_memwr");
      check("sta_we", 16'(bus.mem_we), 16'd1);
      check("sta_enda", 16'(bus.en_da), 16'd0);
      wait_state(3'd5, "prog_reach_halt");
      isa_run();
      check("mem3_isa", 16'(mem[3]), 16'(isa_mem[3]));
      check("mem3_literal", 16'(mem[3]), 16'h0F);
      check("acc_isa", 16'(acc_q), 16'(isa_acc));

      // JZ taken with acc == 0
      clear_prog(); prog[0] = 8'h69;
      do_reset(); run = 1'b1; ack = 1'b1;
      wait_state(3'd2, "jz_taken_decode");
      check("jz_taken_pcld", 16'(bus.pc_ld), 16'd1);
      @(negedge clk); check("jz_taken_pc", 16'(pc_q), 16'd9);

      // JZ not taken after LDI 1
      clear_prog(); prog[0] = 8'h71; prog[1] = 8'h69;
      do_reset(); run = 1'b1; ack = 1'b1;
      wait_state(3'd2, "jz_ldi_decode");
      wait_state(3'd2, "jz_nt_decode");
      check("jz_nt_pcld", 16'(bus.pc_ld), 16'd0);
      @(negedge clk); check("jz_nt_pc", 16'(pc_q), 16'd2);

      // fetch waits three cycles, then a fetch that never completes
      clear_prog();
      do_reset(); run = 1'b1; ack = 1'b0;
      @(negedge clk); check("wait_idle", 16'(state), 16'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 ack = (i == 3);
         @(negedge clk);
         check("wait_req", 16'(bus.mem_req), 16'd1);
         check("wait_irld", 16'(bus.ir_ld), 16'((i == 3) ? 1 : 0));
      end
      @(posedge clk); #1 ack = 1'b0;
      @(negedge clk); check("wait_decode", 16'(state), 16'd2);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.mem_req) n++;
      end
      check("timeout_req_cycles", 16'(n), 16'(WAIT_MAX + 1));
      check("timeout_err", 16'(err), 16'd1);
      check("timeout_halted", 16'(halted), 16'd1);
      check("timeout_req_low", 16'(bus.mem_req), 16'd0);
      quiet_check("timeout_quiet");
      clr_pulse("timeout_clr");

      // clr in the middle of a pending fetch
      clear_prog();
      do_reset(); run = 1'b1; ack = 1'b0;
      @(negedge clk);
      @(negedge clk); check("midclr_req_before", 16'(bus.mem_req), 16'd1);
      #1 clr = 1'b0;
      #1;
      check("midclr_req_after", 16'(bus.mem_req), 16'd0);
      check("midclr_state", 16'(state), 16'd0);
      @(posedge clk); #1 clr = 1'b1;

      // run dropped during LDA's memory read
      clear_prog(); prog[0] = 8'h1A; prog[10] = 8'h55;
      do_reset(); run = 1'b1; ack = 1'b1;
      wait_state(3'd2, "lda_decode");
      @(posedge clk); #1 begin ack = 1'b0; run = 1'b0; end
      @(negedge clk);
      check("lda_memrd", 16'(state), 16'd3);
      check("lda_wait_enda", 16'(bus.en_da), 16'd0);
      @(posedge clk); #1 ack = 1'b1;
      @(negedge clk);
      check("lda_enda", 16'(bus.en_da), 16'd1);
      check("lda_src", 16'(bus.acc_src), 16'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("lda_to_idle", 16'(state), 16'd0);
      check("lda_acc", 16'(acc_q), 16'h55);
      @(posedge clk); #1 run = 1'b1;
      @(negedge clk); check("resume_idle", 16'(state), 16'd0);
      @(negedge clk); check("resume_fetch", 16'(state), 16'd1);
      check("resume_pc", 16'(pc_q), 16'd1);

      // HLT instruction
      clear_prog(); prog[0] = 8'hF0;
      do_reset(); run = 1'b1; ack = 1'b1;
      wait_state(3'd5, "hlt_reach");
      check("hlt_halted", 16'(halted), 16'd1);
      check("hlt_err", 16'(err), 16'd0);
      quiet_check("hlt_quiet");
      clr_pulse("hlt_clr");
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/acc_ctrl.md
Name: acc_ctrl

Overview:
Control sequencer for the 8-bit accumulator processor. It runs fetch/decode/memory sequencing and drives the control strobes for the PC, the instruction register (IR), the memory port, the ALU and the accumulator write-enable (en_da). The datapath blocks hold all data; this block holds only state and a wait-timeout counter.

Parameters:
WAIT_MAX, 15, maximum number of cycles a memory state waits for mem_ack before it flags an error (1..255)

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous active-low reset
run  in  1  enable instruction execution; sampled at instruction boundaries
ir  in  8  IR contents; opcode = ir[7:4], operand/address/immediate = ir[3:0]
acc_zero  in  1  accumulator == 0, from the datapath
mem_ack  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_we  out  1  1 = write accumulator to memory, 0 = read
addr_sel  out  1  memory address source: 0 = PC, 1 = ir[3:0]
ir_ld  out  1  load IR from memory read data
pc_inc  out  1  PC <= PC+1 (mod 16)
pc_ld  out  1  PC <= ir[3:0]
alu_op  out  2  00 pass B, 01 A+B, 10 A-B (mod 256, no carry out)
acc_src  out  2  00 ALU result, 01 memory data, 10 zero-extended ir[3:0]
en_da  out  1  accumulator write enable
halted  out  1  state == HALT
err  out  1  sticky: a memory wait exceeded WAIT_MAX
state  out  3  current state encoding, for debug

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEMRD=3, MEMWR=4, HALT=5. Encodings 6 and 7 are illegal and go to HALT with err=1.
- Reset (clr=0, asynchronous): state=IDLE, wait counter=0, err=0. All outputs are 0 while clr=0.
- Strobes are combinational from state, ir, acc_zero and mem_ack. Each strobe is single-cycle. An output not listed for a state is 0.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: mem_req=1, addr_sel=0.
  - When mem_ack=1: ir_ld=1 and pc_inc=1 in that same cycle; go to DECODE.
- DECODE: one cycle. Decode by opcode:
  - 0 NOP: go to FETCH.
  - 1 LDA: go to MEMRD.
  - 2 STA: go to MEMWR.
  - 3 ADD: go to MEMRD.
  - 4 SUB: go to MEMRD.
  - 5 JMP: pc_ld=1; go to FETCH.
  - 6 JZ: pc_ld=acc_zero; go to FETCH.
  - 7 LDI: en_da=1, acc_src=10; go to FETCH.
  - F HLT: go to HALT.
  - 8..E: treated as NOP.
- MEMRD: mem_req=1, addr_sel=1. alu_op is held at 00 (LDA), 01 (ADD) or 10 (SUB) for the whole state.
  - When mem_ack=1: en_da=1, with acc_src=01 for LDA and 00 for ADD/SUB; go to FETCH.
- MEMWR: mem_req=1, mem_we=1, addr_sel=1.
  - When mem_ack=1: go to FETCH. en_da stays 0.
- HALT: halted=1, all strobes 0. Exited only by clr.
- Run gating: any transition that would enter FETCH goes to IDLE instead if run=0 in that cycle. An instruction already in progress always completes. run=0 never aborts a memory access.
- Wait timeout:
  - The counter clears on entry to FETCH, MEMRD and MEMWR, and increments each cycle in those states while mem_ack=0.
  - If it reaches WAIT_MAX with mem_ack still 0: set err=1, go to HALT, and drop mem_req the next cycle.
  - mem_ack=1 in the same cycle the counter reaches WAIT_MAX counts as success.
- mem_ack outside FETCH/MEMRD/MEMWR is ignored.
- Minimum latency with mem_ack tied high:
  - NOP/JMP/JZ/LDI: 2 cycles.
  - LDA/ADD/SUB/STA: 3 cycles.
  - en_da for LDI falls in cycle 2; for LDA/ADD/SUB in cycle 3.
- clr asserted mid-access: mem_req drops immediately (asynchronously); no partial strobe is held.

Test Plan:
- Reset, then run=1 with mem_ack=1 and IR fed 0x73 (LDI 3): states 0→1→2→1. In the DECODE cycle en_da=1 and acc_src=10; pc_inc=1 in the FETCH cycle only.
- Program LDI 5; ADD @2 (mem[2]=0x0A); STA @3, with mem_ack=1. The ADD's MEMRD cycle shows alu_op=01, acc_src=00, en_da=1, addr_sel=1. The STA's MEMWR cycle shows mem_we=1. The checker model expects mem[3]=0x0F.
- JZ 9 with acc_zero=1 → pc_ld=1 in DECODE. Repeat with acc_zero=0 → pc_ld=0 and the next fetch is PC+1.
- FETCH with mem_ack held low for 3 cycles → mem_req held 4 cycles, ir_ld only in the 4th. With WAIT_MAX=15 and mem_ack never asserted → err=1, halted=1, mem_req=0 thereafter.
- Drop run=0 during MEMRD of LDA → the access completes with en_da=1, then state goes to IDLE (not FETCH). Reasserting run=1 resumes at FETCH.
- Fetch opcode 0xF0 → halted=1, outputs stay quiet for 20 cycles despite run=1 and mem_ack pulses. Then clr=0 for one cycle mid-state → state=0 and err=0 asynchronously.
